perm_scrambler_gen: RTL and testbench
=====================================

Name: perm_scrambler_gen

Overview:
Parametrised successor to the fixed six-slot scrambler/checker pair. It generates an N-entry permutation of 0..N-1 in one of four modes: identity, LFSR Fisher-Yates shuffle, rotate, or reverse. A built-in sequential checker then confirms that every value appears exactly once. A ready/done handshake frames each request, and the checked result is held on a flat output bus until the next request.

Parameters:
N, 6, number of permutation slots (2..16)
W, 3, bits per slot index; must satisfy 2**W >= N
SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
ready  input  1  start request; sampled only in IDLE
mode  input  2  00 identity, 01 shuffle, 10 rotate, 11 reverse
index  input  W  rotate amount (mode 10) or LFSR mix-in value (mode 01); sampled with ready
perm  output  N*W  result bus; slot k is perm[k*W +: W]
busy  output  1  high from LOAD through CHECK
done  output  1  one-cycle pulse when a result is complete
valid  output  1  high while perm holds a checked result
err  output  1  checker verdict for the current result; 1 means not a permutation

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, lfsr=SEED.
  - Every slot k = k, so perm is the identity.
  - busy=0, done=0, valid=0, err=0.
- States: IDLE -> LOAD -> (SHUFFLE if mode==01) -> CHECK -> DONE -> IDLE.
- IDLE:
  - ready=1 latches mode and index, clears valid, and moves to LOAD.
  - ready is ignored in every other state.
- LOAD (1 cycle), slot k is written according to the latched mode:
  - 00: k
  - 01: k; also lfsr <= lfsr ^ zero-extended index; if the result would be 0, lfsr <= SEED instead.
  - 10: (k + index mod N) mod N; index >= N is reduced mod N first.
  - 11: N-1-k
- SHUFFLE (mode 01 only):
  - Pointer i starts at N-1.
  - Every cycle, lfsr advances one step: 16-bit Galois LFSR, shift right, XOR 16'hB400 when the shifted-out bit is 1.
  - Candidate r = low W bits of lfsr before the step.
  - If r <= i: swap slot i with slot r (r==i is a no-op), then decrement i.
  - If r > i: reject; i is unchanged.
  - Exit to CHECK when i reaches 0 after a swap.
  - Cycle count is data-dependent but deterministic for a given SEED, index history and reset point.
  - lfsr does not advance outside SHUFFLE.
- CHECK (exactly N cycles):
  - Cycle c examines slot c against an N-bit seen mask cleared on entry.
  - err_acc is set if slot value >= N or its seen bit is already 1; otherwise the seen bit is set.
- DONE (1 cycle): done=1, valid=1, err=err_acc, busy=0, then return to IDLE.
  - The earliest new ready is accepted in the following IDLE cycle.
- Latency for modes 00/10/11: ready sampled at edge 0 -> done high after edge N+2 (cycle 8 for N=6).
- Latency for mode 01: N+2 edges plus the SHUFFLE cycles.
- perm is stable from DONE until the next accepted ready; it changes only in LOAD and SHUFFLE.
- err holds its value until the next DONE.
- Reset mid-operation aborts immediately to the reset values, including lfsr=SEED.
- The checker is structural protection; in correct operation err is always 0.

Test Plan:
- Reset, then mode=00, pulse ready -> done pulses exactly once at cycle 8; perm slots 0,1,2,3,4,5; valid=1; err=0; busy high cycles 1-7.
- mode=10, index=2 -> slots 2,3,4,5,0,1. Repeat with index=7 -> slots 1,2,3,4,5,0 (7 mod 6). err=0 in both cases.
- mode=11 -> slots 5,4,3,2,1,0; err=0; perm unchanged for 20 idle cycles afterwards.
- Reset, mode=01, index=0; run twice, each run preceded by a reset -> both runs produce an identical permutation matching the golden model, with a distinct value in every slot and err=0. A run with index=3 matches the golden model's distinct result.
- Hold ready=1 throughout a mode=01 request -> only one request is accepted per IDLE visit; busy never drops mid-run; done is a single-cycle pulse per request.
- Assert rst low during SHUFFLE -> outputs return to reset values asynchronously; a subsequent mode=01 run reproduces the post-reset golden permutation.

Source files
------------

// File: rtl/perm_scrambler_gen.sv
// perm_scrambler_gen: builds an N-slot permutation of 0..N-1 in one of four
// modes (identity, LFSR Fisher-Yates shuffle, rotate, reverse), then runs a
// sequential uniqueness check over the slots before presenting the result.
//
// Handshake timing: the FSM state advances on the accepting edge, and the
// status outputs (busy/done/valid/err) are registered from the state, so they
// trail the state by one cycle. For the fixed modes this places busy over
// cycles 1..N+1 and the single done pulse in cycle N+2 after the accepting edge.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for ready; result and verdict held
//   S_LOAD    | slots written from latched mode/index; LFSR mixed in mode 01
//   S_SHUFFLE | one Fisher-Yates step per cycle, rejecting candidates > ptr
//   S_CHECK   | one slot per cycle against the seen mask, N cycles
//   S_DONE    | verdict latched; outputs report done/valid next cycle

module perm_scrambler_gen #(
   parameter int          N    = 6,
   parameter int          W    = 3,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ready,
   input  logic [1:0]     mode,
   input  logic [W-1:0]   index,
   output logic [N*W-1:0] perm,
   output logic           busy,
   output logic           done,
   output logic           valid,
   output logic           err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHUFFLE,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [1:0] M_IDENT   = 2'b00;
   localparam logic [1:0] M_SHUFFLE = 2'b01;
   localparam logic [1:0] M_ROTATE  = 2'b10;
   localparam logic [1:0] M_REVERSE = 2'b11;

   state_t        state;
   logic [1:0]    mode_q;
   logic [W-1:0]  index_q;
   logic [15:0]   lfsr;
   logic [W-1:0]  slot [N];
   logic [W-1:0]  ptr;
   logic [W-1:0]  cnt;
   logic [N-1:0]  seen;
   logic          err_acc;

   logic [W-1:0]  rot;
   logic [W-1:0]  load_val [N];
   logic [15:0]   lfsr_step;
   logic [15:0]   lfsr_mix;
   logic [W-1:0]  cand;
   logic [W-1:0]  chk_val;
   logic          chk_bad;
   logic [N-1:0]  seen_set;

   // Rotate amount reduced mod N, and the per-slot value LOAD will write.
   always_comb begin
      rot = W'(32'(index_q) % N);
      for (int k = 0; k < N; k++) begin
         load_val[k] = W'(k);
         case (mode_q)
            M_IDENT, M_SHUFFLE: load_val[k] = W'(k);
            M_ROTATE: begin
               if ((32'(k) + 32'(rot)) >= 32'(N))
                  load_val[k] = W'(32'(k) + 32'(rot) - 32'(N));
               else
                  load_val[k] = W'(32'(k) + 32'(rot));
            end
            M_REVERSE: load_val[k] = W'(N - 1 - k);
            default:   load_val[k] = W'(k);
         endcase
      end
   end

   // Galois LFSR step, index mix-in with the all-zero lockup state avoided,
   // and the shuffle candidate taken from the pre-step value.
   always_comb begin
      lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      lfsr_mix  = lfsr ^ 16'(index_q);
      if (lfsr_mix == 16'h0000)
         lfsr_mix = SEED;
      cand = lfsr[W-1:0];
   end

   // Checker datapath: out-of-range or repeated values flag an error.
   always_comb begin
      chk_val  = slot[cnt];
      seen_set = seen;
      chk_bad  = 1'b0;
      if (32'(chk_val) >= 32'(N))
         chk_bad = 1'b1;
      for (int j = 0; j < N; j++) begin
         if (32'(chk_val) == 32'(j)) begin
            if (seen[j])
               chk_bad = 1'b1;
            seen_set[j] = 1'b1;
         end
      end
   end

   // Flatten the slot array onto the result bus.
   always_comb begin
      perm = '0;
      for (int k = 0; k < N; k++)
         perm[k*W +: W] = slot[k];
   end

   // Sequencer, slot storage, LFSR and registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         mode_q  <= M_IDENT;
         index_q <= '0;
         lfsr    <= SEED;
         ptr     <= '0;
         cnt     <= '0;
         seen    <= '0;
         err_acc <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         valid   <= 1'b0;
         err     <= 1'b0;
         for (int k = 0; k < N; k++)
            slot[k] <= W'(k);
      end else begin
         busy <= (state == S_LOAD) || (state == S_SHUFFLE) || (state == S_CHECK);
         done <= (state == S_DONE);
         if (state == S_DONE) begin
            valid <= 1'b1;
            err   <= err_acc;
         end

         case (state)
            S_IDLE: begin
               if (ready) begin
                  mode_q  <= mode;
                  index_q <= index;
                  valid   <= 1'b0;
                  state   <= S_LOAD;
               end
            end

            S_LOAD: begin
               for (int k = 0; k < N; k++)
                  slot[k] <= load_val[k];
               ptr     <= W'(N - 1);
               cnt     <= '0;
               seen    <= '0;
               err_acc <= 1'b0;
               if (mode_q == M_SHUFFLE) begin
                  lfsr  <= lfsr_mix;
                  state <= S_SHUFFLE;
               end else begin
                  state <= S_CHECK;
               end
            end

            S_SHUFFLE: begin
               lfsr <= lfsr_step;
               if (cand <= ptr) begin
                  // Both writes target the same slot when cand == ptr, which
                  // leaves the value in place.
                  slot[ptr]  <= slot[cand];
                  slot[cand] <= slot[ptr];
                  ptr        <= ptr - W'(1);
                  if (ptr == W'(1))
                     state <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (chk_bad)
                  err_acc <= 1'b1;
               seen <= seen_set;
               cnt  <= cnt + W'(1);
               if (cnt == W'(N - 1))
                  state <= S_DONE;
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_perm_scrambler_gen.sv
// Bench for perm_scrambler_gen (N=6, W=3, SEED=ACE1). A behavioural model
// computes each expected permutation from the mode rules; a per-cycle compare
// process checks any held result, and literals pin the model and timing.

module tb_perm_scrambler_gen;

   localparam int          N    = 6;
   localparam int          W    = 3;
   localparam logic [15:0] SEED = 16'hACE1;

   logic           clk;
   logic           rst;
   logic           ready;
   logic [1:0]     mode;
   logic [W-1:0]   index;
   logic [N*W-1:0] perm;
   logic           busy;
   logic           done;
   logic           valid;
   logic           err;

   int             n_chk;
   int             n_pass;
   logic [N*W-1:0] exp_perm;
   logic [15:0]    mlf;
   bit             cmp_en;

   perm_scrambler_gen #(.N(N), .W(W), .SEED(SEED)) dut (
      .clk   (clk),
      .rst   (rst),
      .ready (ready),
      .mode  (mode),
      .index (index),
      .perm  (perm),
      .busy  (busy),
      .done  (done),
      .valid (valid),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   function automatic logic [N*W-1:0] pk6(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5);
      return {3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
   endfunction

   function automatic bit is_perm(input logic [N*W-1:0] p);
      int cnt [N];
      int v;
      for (int k = 0; k < N; k++) cnt[k] = 0;
      for (int k = 0; k < N; k++) begin
         v = int'(p[k*W +: W]);
         if (v >= N) return 1'b0;
         cnt[v]++;
      end
      for (int k = 0; k < N; k++)
         if (cnt[k] != 1) return 1'b0;
      return 1'b1;
   endfunction

   // Expected permutation straight from the mode rules; lf carries the LFSR
   // history between requests, cyc returns the number of shuffle steps.
   function automatic logic [N*W-1:0] model(input logic [1:0] m, input logic [W-1:0] ix,
                                            inout logic [15:0] lf, output int cyc);
      int a [N];
      int i, r, t;
      logic [N*W-1:0] p;
      cyc = 0;
      for (int k = 0; k < N; k++) begin
         case (m)
            2'b10:   a[k] = (k + (int'(ix) % N)) % N;
            2'b11:   a[k] = N - 1 - k;
            default: a[k] = k;
         endcase
      end
      if (m == 2'b01) begin
         lf = lf ^ 16'(ix);
         if (lf == 16'h0) lf = SEED;
         i = N - 1;
         while (i > 0 && cyc < 2000) begin
            r  = int'(lf) % (1 << W);
            lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
            cyc++;
            if (r <= i) begin
               t = a[i]; a[i] = a[r]; a[r] = t;
               i--;
            end
         end
      end
      p = '0;
      for (int k = 0; k < N; k++) p[k*W +: W] = W'(a[k]);
      return p;
   endfunction

   // Whenever a result is held it must match the model; done must carry a clean verdict.
   always @(negedge clk) begin
      if (cmp_en && rst) begin
         if (done) begin
            check("cmp_done_valid", 64'(valid), 64'd1);
            check("cmp_done_err", 64'(err), 64'd0);
         end
         if (valid)
            check("cmp_perm", 64'(perm), 64'(exp_perm));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b0;
      ready = 1'b0;
      mlf   = SEED;
      @(negedge clk);
      check("rst_perm", 64'(perm), 64'(pk6(0, 1, 2, 3, 4, 5)));
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_req(input logic [1:0] m, input logic [W-1:0] ix, input bit hold,
                          input string nm, output int lat_seen);
      int cyc, lat;
      logic [N*W-1:0] nxt;
      bit got;
      nxt = model(m, ix, mlf, cyc);
      lat = N + 2 + cyc;
      @(negedge clk);
      mode  = m;
      index = ix;
      ready = 1'b1;
      @(posedge clk);
      #1;
      exp_perm = nxt;
      if (!hold) ready = 1'b0;
      @(negedge clk);
      check({nm, "_busy_c0"}, 64'(busy), 64'd0);
      got = 1'b0;
      lat_seen = 0;
      for (int t = 1; t <= lat + 20 && !got; t++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            lat_seen = t;
         end else begin
            check({nm, "_busy"}, 64'(busy), 64'd1);
         end
      end
      check({nm, "_done_seen"}, 64'(got), 64'd1);
      check({nm, "_latency"}, 64'(lat_seen), 64'(lat));
      check({nm, "_perm"}, 64'(perm), 64'(nxt));
      check({nm, "_is_perm"}, 64'(is_perm(perm)), 64'd1);
      check({nm, "_err"}, 64'(err), 64'd0);
      check({nm, "_valid"}, 64'(valid), 64'd1);
      ready = 1'b0;
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         check({nm, "_done_pulse"}, 64'(done), 64'd0);
         check({nm, "_idle_busy"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      int lat;
      int mcyc;
      logic [15:0] tlf;
      logic [N*W-1:0] p1;
      n_chk    = 0;
      n_pass   = 0;
      cmp_en   = 1'b0;
      rst      = 1'b1;
      ready    = 1'b0;
      mode     = 2'b00;
      index    = '0;
      mlf      = SEED;
      exp_perm = pk6(0, 1, 2, 3, 4, 5);

      // Pin the model against a hand-worked shuffle from SEED with index 0.
      tlf = SEED;
      p1  = model(2'b01, 3'd0, tlf, mcyc);
      check("model_shuffle_perm", 64'(p1), 64'(pk6(3, 2, 5, 4, 0, 1)));
      check("model_shuffle_cycles", 64'(mcyc), 64'd11);

      #2;
      do_reset();
      cmp_en = 1'b1;

      run_req(2'b00, 3'd0, 1'b0, "ident", lat);
      check("ident_lat_lit", 64'(lat), 64'd8);
      check("ident_lit", 64'(perm), 64'(pk6(0, 1, 2, 3, 4, 5)));

      run_req(2'b10, 3'd2, 1'b0, "rot2", lat);
      check("rot2_lit", 64'(perm), 64'(pk6(2, 3, 4, 5, 0, 1)));
      run_req(2'b10, 3'd7, 1'b0, "rot7", lat);
      check("rot7_lit", 64'(perm), 64'(pk6(1, 2, 3, 4, 5, 0)));

      run_req(2'b11, 3'd0, 1'b0, "rev", lat);
      check("rev_lit", 64'(perm), 64'(pk6(5, 4, 3, 2, 1, 0)));
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         check("rev_hold_perm", 64'(perm), 64'(pk6(5, 4, 3, 2, 1, 0)));
         check("rev_hold_valid", 64'(valid), 64'd1);
      end

      do_reset();
      run_req(2'b01, 3'd0, 1'b0, "shuf_a", lat);
      check("shuf_a_lit", 64'(perm), 64'(pk6(3, 2, 5, 4, 0, 1)));
      check("shuf_a_lat_lit", 64'(lat), 64'd19);
      p1 = perm;
      do_reset();
      run_req(2'b01, 3'd0, 1'b0, "shuf_b", lat);
      check("shuf_repeat", 64'(perm), 64'(p1));

      run_req(2'b01, 3'd3, 1'b0, "shuf_ix3", lat);
      run_req(2'b01, 3'd5, 1'b1, "shuf_hold", lat);

      // Abort a shuffle with an asynchronous reset between clock edges.
      do_reset();
      @(negedge clk);
      mode  = 2'b01;
      index = 3'd0;
      ready = 1'b1;
      @(posedge clk);
      #1;
      ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_perm", 64'(perm), 64'(pk6(0, 1, 2, 3, 4, 5)));
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_valid", 64'(valid), 64'd0);
      check("abort_err", 64'(err), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      mlf = SEED;
      run_req(2'b01, 3'd0, 1'b0, "shuf_post", lat);
      check("shuf_post_lit", 64'(perm), 64'(pk6(3, 2, 5, 4, 0, 1)));

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, expected finish before 500000");
      $fatal(1);
   end

endmodule
